// File: rtl/as_sc_hs_cell_bist.sv
// BIST driver/checker for sky130_as_sc_hs combinational cells: an LFSR drives the CUT,
// RESP is sampled SETTLE+1 cycles later and scored against a golden cell model.
module as_sc_hs_cell_bist #(
    parameter int          SETTLE = 2,
    parameter int          CNT_W  = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [3:0]       CELL_SEL,
    input  logic [CNT_W-1:0] NUM_VEC,
    output logic [3:0]       STIM,
    input  logic             RESP,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] FIRST_ERR_VEC
);
    localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO        = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2
    } state_e;

    function automatic logic golden(input logic [3:0] sel, input logic [3:0] s);
        logic a, b, c, d, y;
        a = s[0];
        b = s[1];
        c = s[2];
        d = s[3];
        case (sel)
            4'd0:    y = ~a;
            4'd1:    y = a;
            4'd2:    y = ~(a & b);
            4'd3:    y = ~(a & b & c);
            4'd4:    y = ~(a & b & c & d);
            4'd5:    y = ~(a | b);
            4'd6:    y = ~(a | b | c);
            4'd7:    y = a & b;
            4'd8:    y = a | b;
            4'd9:    y = ~(a ^ b);
            4'd10:   y = (a & b) | (b & c) | (a & c);
            4'd11:   y = ~((a & b) | c | d);
            4'd12:   y = ~((a | b) & c & d);
            4'd13:   y = c ? b : a;
            4'd14:   y = a | ~b;
            4'd15:   y = ~a & b;
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [3:0]       cell_q, cell_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             mismatch_s;
    logic [CNT_W-1:0] err_inc_s;

    // Next-state and datapath update for the IDLE/SETTLE/SAMPLE sequencer
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        settle_d   = settle_q;
        vec_idx_d  = vec_idx_q;
        num_vec_d  = num_vec_q;
        cell_d     = cell_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        first_d    = first_q;
        mismatch_s = (RESP != golden(cell_q, lfsr_q[3:0]));
        err_inc_s  = (err_q == ALL_ONES) ? err_q : (err_q + ONE);
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    err_d   = ZERO;
                    first_d = ALL_ONES;
                    if (NUM_VEC != ZERO) begin
                        lfsr_d    = SEED;
                        settle_d  = {SW{1'b0}};
                        vec_idx_d = ZERO;
                        num_vec_d = NUM_VEC;
                        cell_d    = CELL_SEL;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        state_d   = S_SETTLE;
                    end else begin
                        done_d = 1'b1;
                        pass_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = {SW{1'b0}};
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_SAMPLE: begin
                // A zero count before this sample means this is the first mismatch
                if (mismatch_s) begin
                    err_d = err_inc_s;
                    if (err_q == ZERO) begin
                        first_d = vec_idx_q;
                    end else begin
                        first_d = first_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (vec_idx_q == (num_vec_q - ONE)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == ZERO);
                    state_d = S_IDLE;
                end else begin
                    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    vec_idx_d = vec_idx_q + ONE;
                    state_d   = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 16'h0000;
            settle_q  <= {SW{1'b0}};
            vec_idx_q <= ZERO;
            num_vec_q <= ZERO;
            cell_q    <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= ZERO;
            first_q   <= ALL_ONES;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            settle_q  <= settle_d;
            vec_idx_q <= vec_idx_d;
            num_vec_q <= num_vec_d;
            cell_q    <= cell_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign STIM          = lfsr_q[3:0];
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign PASS          = pass_q;
    assign ERR_CNT       = err_q;
    assign FIRST_ERR_VEC = first_q;
endmodule
